// File: rtl/spi_feeder.sv
// Feeds buffered waveform samples to the SPI master, one frame per sample,
// merging pending clear requests into the next frame and returning the received word.
module spi_feeder #(
    parameter int bits    = 8,
    parameter int depth   = 4,
    parameter int gap     = 2,
    parameter int timeout = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic [bits-1:0]          sample,
    output logic                     sample_ready,
    input  logic                     clear_req,
    output logic                     spi_en,
    output logic                     spi_clr_ctrl,
    output logic [bits-1:0]          spi_data,
    input  logic                     spi_ss,
    input  logic [bits-1:0]          spi_rec,
    output logic                     rec_valid,
    output logic [bits-1:0]          rec_data,
    output logic                     busy,
    output logic                     err,
    output logic [$clog2(depth):0]   level
);

    localparam int aw = $clog2(depth);
    localparam int lw = aw + 1;
    localparam int gw = $clog2(gap + 1);
    localparam int tw = $clog2(timeout + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [lw-1:0]   level_q, level_d;
    logic [gw-1:0]   gap_cnt_q, gap_cnt_d;
    logic [tw-1:0]   tout_cnt_q, tout_cnt_d;
    logic            clear_pend_q, clear_pend_d;
    logic            spi_en_q, spi_en_d;
    logic            spi_clr_q, spi_clr_d;
    logic [bits-1:0] spi_data_q, spi_data_d;
    logic            rec_valid_q, rec_valid_d;
    logic [bits-1:0] rec_data_q, rec_data_d;
    logic            err_q, err_d;
    logic            push, pop, consume;

    logic [bits-1:0] fifo_mem [depth];

    assign sample_ready = (level_q != lw'(depth));
    assign push         = sample_valid && sample_ready;
    assign spi_en       = spi_en_q;
    assign spi_clr_ctrl = spi_clr_q;
    assign spi_data     = spi_data_q;
    assign rec_valid    = rec_valid_q;
    assign rec_data     = rec_data_q;
    assign busy         = (state_q != IDLE);
    assign err          = err_q;
    assign level        = level_q;

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sample;
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        tout_cnt_d = tout_cnt_q;
        spi_en_d   = 1'b0;
        spi_clr_d  = spi_clr_q;
        spi_data_d = spi_data_q;
        rec_valid_d = 1'b0;
        rec_data_d = rec_data_q;
        err_d      = err_q;
        pop        = 1'b0;
        consume    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gap_cnt_q == '0 && (level_q != '0 || clear_pend_q)) begin
                    state_d   = LOAD;
                    spi_en_d  = 1'b1;
                    spi_clr_d = clear_pend_q;
                    consume   = 1'b1;
                    if (level_q != '0) begin
                        pop        = 1'b1;
                        spi_data_d = fifo_mem[rd_ptr_q];
                    end else begin
                        spi_data_d = '0;
                    end
                end
            end
            LOAD: begin
                state_d    = WAIT_LOW;
                tout_cnt_d = '0;
            end
            WAIT_LOW: begin
                if (!spi_ss) begin
                    state_d = WAIT_HIGH;
                end else if (tout_cnt_q == tw'(timeout - 1)) begin
                    err_d     = 1'b1;
                    gap_cnt_d = gw'(gap);
                    state_d   = GAP;
                end else begin
                    tout_cnt_d = tout_cnt_q + tw'(1);
                end
            end
            WAIT_HIGH: begin
                if (spi_ss) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rec_valid_d = 1'b1;
                rec_data_d  = spi_rec;
                gap_cnt_d   = gw'(gap);
                state_d     = GAP;
            end
            GAP: begin
                if (gap_cnt_q <= gw'(1)) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - gw'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request arriving on the consuming edge must survive for the following frame.
    always_comb begin
        clear_pend_d = clear_req || (clear_pend_q && !consume);
        wr_ptr_d     = push ? wr_ptr_q + aw'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + aw'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + lw'(1);
            2'b01:   level_d = level_q - lw'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            gap_cnt_q    <= '0;
            tout_cnt_q   <= '0;
            clear_pend_q <= 1'b0;
            spi_en_q     <= 1'b0;
            spi_clr_q    <= 1'b0;
            spi_data_q   <= '0;
            rec_valid_q  <= 1'b0;
            rec_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            gap_cnt_q    <= gap_cnt_d;
            tout_cnt_q   <= tout_cnt_d;
            clear_pend_q <= clear_pend_d;
            spi_en_q     <= spi_en_d;
            spi_clr_q    <= spi_clr_d;
            spi_data_q   <= spi_data_d;
            rec_valid_q  <= rec_valid_d;
            rec_data_q   <= rec_data_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_feeder.sv
// Directed bench for spi_feeder with a loopback SPI master model driving spi_ss/spi_rec.
module tb_spi_feeder;

    localparam int gap_cycles     = 2;
    localparam int timeout_cycles = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [7:0] sample;
    logic       sample_ready;
    logic       clear_req;
    logic       spi_en;
    logic       spi_clr_ctrl;
    logic [7:0] spi_data;
    logic       spi_ss;
    logic [7:0] spi_rec;
    logic       rec_valid;
    logic [7:0] rec_data;
    logic       busy;
    logic       err;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Master model state and observation logs
    int         low_len      = 8;
    int         stuck_frames = 0;
    bit         m_active     = 1'b0;
    int         m_cnt        = 0;
    logic [7:0] m_word       = 8'h00;
    bit         en_prev      = 1'b0;
    bit         have_rec     = 1'b0;
    int         last_rec_cyc = 0;
    int         ss_rise_cyc  = 0;
    int         en_b2b       = 0;
    int         spacing_err  = 0;
    logic [7:0] frm_data [$];
    logic       frm_clr  [$];
    int         frm_cyc  [$];
    logic [7:0] rec_log  [$];

    spi_feeder #(.bits(8), .depth(4), .gap(gap_cycles), .timeout(timeout_cycles)) dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample(sample), .sample_ready(sample_ready),
        .clear_req(clear_req),
        .spi_en(spi_en), .spi_clr_ctrl(spi_clr_ctrl), .spi_data(spi_data),
        .spi_ss(spi_ss), .spi_rec(spi_rec),
        .rec_valid(rec_valid), .rec_data(rec_data),
        .busy(busy), .err(err), .level(level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Loopback master: ss drops the cycle after en, stays low low_len cycles, then returns the sent word.
    always @(negedge clk) begin
        if (rst) begin
            spi_ss   = 1'b1;
            m_active = 1'b0;
            en_prev  = 1'b0;
        end else begin
            if (spi_en) begin
                frm_data.push_back(spi_data);
                frm_clr.push_back(spi_clr_ctrl);
                frm_cyc.push_back(cyc);
                if (en_prev) en_b2b++;
                if (have_rec && (cyc - last_rec_cyc) < gap_cycles + 1) spacing_err++;
            end
            en_prev = spi_en;
            if (rec_valid) begin
                rec_log.push_back(rec_data);
                last_rec_cyc = cyc;
                have_rec     = 1'b1;
            end
            if (m_active) begin
                if (m_cnt == 0) spi_ss = 1'b0;
                m_cnt++;
                if (m_cnt > low_len) begin
                    spi_ss      = 1'b1;
                    spi_rec     = m_word;
                    ss_rise_cyc = cyc;
                    m_active    = 1'b0;
                end
            end else if (spi_en) begin
                if (stuck_frames > 0) begin
                    stuck_frames--;
                end else begin
                    m_active = 1'b1;
                    m_cnt    = 0;
                    m_word   = spi_data;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        frm_data.delete();
        frm_clr.delete();
        frm_cyc.delete();
        rec_log.delete();
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int n = 0;
        while ((busy || level != 3'd0) && n < limit) begin
            tick();
            n++;
        end
        ok = !(busy || level != 3'd0);
    endtask

    task automatic wait_frames(input int count, input int limit, output bit ok);
        int n = 0;
        while (frm_data.size() < count && n < limit) begin
            tick();
            n++;
        end
        ok = (frm_data.size() >= count);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        sample = 8'h00;
        clear_req = 1'b0;
        spi_ss = 1'b1;
        spi_rec = 8'h00;
        tick();
        tick();
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        checks++; if (sample_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", sample_ready); end
        checks++; if (busy !== 1'b0 || spi_en !== 1'b0 || err !== 1'b0 || rec_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_flags: got busy=%b en=%b err=%b rv=%b expected all 0", busy, spi_en, err, rec_valid); end
        checks++; if (spi_data !== 8'h00 || spi_clr_ctrl !== 1'b0 || rec_data !== 8'h00) begin
            failures++; $display("[TB] FAIL reset_data: got data=%h clr=%b rec=%h expected 0", spi_data, spi_clr_ctrl, rec_data); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || spi_en !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle: got busy=%b en=%b expected 0", busy, spi_en); end
    endtask

    task automatic test_single_frame();
        bit ok;
        clear_logs();
        tick();
        sample_valid = 1'b1;
        sample = 8'hA5;
        tick();
        sample_valid = 1'b0;
        checks++; if (level !== 3'd1 || spi_en !== 1'b0) begin failures++; $display("[TB] FAIL single_push: got level=%0d en=%b expected 1/0", level, spi_en); end
        tick();
        checks++; if (spi_en !== 1'b1) begin failures++; $display("[TB] FAIL single_en: got %b expected 1", spi_en); end
        checks++; if (spi_data !== 8'hA5 || spi_clr_ctrl !== 1'b0) begin failures++; $display("[TB] FAIL single_load: got data=%h clr=%b expected a5/0", spi_data, spi_clr_ctrl); end
        checks++; if (level !== 3'd0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL single_pop: got level=%0d busy=%b expected 0/1", level, busy); end
        tick();
        checks++; if (spi_en !== 1'b0) begin failures++; $display("[TB] FAIL single_en_width: got %b expected 0", spi_en); end
        wait_idle(100, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL single_idle: got busy=%b expected 0 within bound", busy); end
        repeat (4) tick();
        checks++; if (rec_log.size() != 1 || frm_data.size() != 1) begin
            failures++; $display("[TB] FAIL single_counts: got recs=%0d frames=%0d expected 1/1", rec_log.size(), frm_data.size()); end
        checks++; if (rec_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_rec_data: got %h expected a5", rec_data); end
        checks++; if (last_rec_cyc - ss_rise_cyc != 2) begin
            failures++; $display("[TB] FAIL single_rec_latency: got %0d expected 2", last_rec_cyc - ss_rise_cyc); end
    endtask

    task automatic test_fifo_fill();
        bit ok;
        clear_logs();
        for (int w = 1; w <= 5; w++) begin
            tick();
            sample_valid = 1'b1;
            sample = 8'(w);
        end
        tick();
        sample = 8'h66;
        checks++; if (level !== 3'd4 || sample_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL fill_full: got level=%0d ready=%b expected 4/0", level, sample_ready); end
        tick();
        sample_valid = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL fill_push_ignored: got level=%0d expected 4", level); end
        wait_idle(400, ok);
        repeat (4) tick();
        checks++; if (!ok || frm_data.size() != 5 || rec_log.size() != 5) begin
            failures++; $display("[TB] FAIL fill_counts: got frames=%0d recs=%0d expected 5/5", frm_data.size(), rec_log.size()); end
        for (int i = 0; i < 5 && i < frm_data.size() && i < rec_log.size(); i++) begin
            checks++; if (frm_data[i] !== 8'(i + 1) || rec_log[i] !== 8'(i + 1)) begin
                failures++; $display("[TB] FAIL fill_order_%0d: got tx=%h rx=%h expected %h", i, frm_data[i], rec_log[i], 8'(i + 1)); end
        end
        checks++; if (spacing_err != 0 || en_b2b != 0) begin
            failures++; $display("[TB] FAIL fill_spacing: got spacing_err=%0d b2b=%0d expected 0/0", spacing_err, en_b2b); end
    endtask

    task automatic test_clear_only();
        bit ok;
        clear_logs();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        checks++; if (spi_en !== 1'b1 || spi_clr_ctrl !== 1'b1 || spi_data !== 8'h00) begin
            failures++; $display("[TB] FAIL clear_only_frame: got en=%b clr=%b data=%h expected 1/1/00", spi_en, spi_clr_ctrl, spi_data); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL clear_only_level: got %0d expected 0", level); end
        wait_idle(100, ok);
        repeat (6) tick();
        checks++; if (!ok || frm_data.size() != 1 || rec_log.size() != 1) begin
            failures++; $display("[TB] FAIL clear_only_counts: got frames=%0d recs=%0d expected 1/1", frm_data.size(), rec_log.size()); end
        checks++; if (spi_clr_ctrl !== 1'b1) begin failures++; $display("[TB] FAIL clear_only_hold: got %b expected 1", spi_clr_ctrl); end
    endtask

    task automatic test_clear_during_frame();
        bit ok;
        clear_logs();
        tick();
        sample_valid = 1'b1;
        sample = 8'h10;
        tick();
        sample = 8'h20;
        tick();
        sample_valid = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        sample_valid = 1'b1;
        sample = 8'h30;
        tick();
        sample_valid = 1'b0;
        wait_frames(3, 300, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL clrmid_frames: got %0d expected 3", frm_data.size()); end
        wait_idle(100, ok);
        if (frm_data.size() >= 3) begin
            checks++; if (frm_data[0] !== 8'h10 || frm_clr[0] !== 1'b0) begin
                failures++; $display("[TB] FAIL clrmid_f0: got %h/%b expected 10/0", frm_data[0], frm_clr[0]); end
            checks++; if (frm_data[1] !== 8'h20 || frm_clr[1] !== 1'b1) begin
                failures++; $display("[TB] FAIL clrmid_f1: got %h/%b expected 20/1", frm_data[1], frm_clr[1]); end
            checks++; if (frm_data[2] !== 8'h30 || frm_clr[2] !== 1'b0) begin
                failures++; $display("[TB] FAIL clrmid_f2: got %h/%b expected 30/0", frm_data[2], frm_clr[2]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        int diff;
        clear_logs();
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL timeout_pre_err: got %b expected 0", err); end
        stuck_frames = 1;
        tick();
        sample_valid = 1'b1;
        sample = 8'h77;
        tick();
        sample = 8'h88;
        tick();
        sample_valid = 1'b0;
        wait_frames(1, 20, ok);
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        diff = (frm_cyc.size() > 0) ? cyc - frm_cyc[0] : -1;
        checks++; if (err !== 1'b1 || diff < timeout_cycles || diff > timeout_cycles + 1) begin
            failures++; $display("[TB] FAIL timeout_err: got err=%b after %0d cycles expected 1 after %0d..%0d", err, diff, timeout_cycles, timeout_cycles + 1); end
        checks++; if (rec_log.size() != 0) begin failures++; $display("[TB] FAIL timeout_no_rec: got %0d recs expected 0", rec_log.size()); end
        wait_frames(2, 60, ok);
        wait_idle(100, ok);
        repeat (4) tick();
        checks++; if (frm_data.size() != 2 || rec_log.size() != 1) begin
            failures++; $display("[TB] FAIL timeout_counts: got frames=%0d recs=%0d expected 2/1", frm_data.size(), rec_log.size()); end
        checks++; if (rec_data !== 8'h88 || (frm_data.size() > 1 && frm_data[1] !== 8'h88)) begin
            failures++; $display("[TB] FAIL timeout_next_word: got rec=%h expected 88", rec_data); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_sticky: got %b expected 1", err); end
    endtask

    task automatic test_async_reset();
        int n;
        clear_logs();
        low_len = 40;
        for (int w = 0; w < 4; w++) begin
            tick();
            sample_valid = 1'b1;
            sample = 8'(8'hC1 + w);
        end
        tick();
        sample_valid = 1'b0;
        n = 0;
        while (spi_ss !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++; if (busy !== 1'b1 || level !== 3'd3) begin
            failures++; $display("[TB] FAIL areset_pre: got busy=%b level=%0d expected 1/3", busy, level); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (level !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL areset_state: got level=%0d busy=%b expected 0/0", level, busy); end
        checks++; if (spi_en !== 1'b0 || err !== 1'b0 || sample_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL areset_outputs: got en=%b err=%b ready=%b expected 0/0/1", spi_en, err, sample_ready); end
        tick();
        rst = 1'b0;
        low_len = 8;
        repeat (10) tick();
        checks++; if (frm_data.size() != 1 || busy !== 1'b0 || level !== 3'd0) begin
            failures++; $display("[TB] FAIL areset_quiet: got frames=%0d busy=%b level=%0d expected 1/0/0", frm_data.size(), busy, level); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fifo_fill();
        test_clear_only();
        test_clear_during_frame();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
